// File: rtl/scoreboard_scan_ctrl.sv
// Win/lose event scoreboard with match result tracking and a digit refresh
// scanner feeding the seven-segment display stage.
module scoreboard_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned MAX_SCORE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win_in,
    input  logic       lose_in,
    input  logic       clear,
    output logic [3:0] win,
    output logic [3:0] lose,
    output logic [1:0] digit_sel,
    output logic       game_over
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WON  = 2'd1,
        ST_LOST = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   lose_cnt_q, lose_cnt_d;
    logic               win_prev_q, win_prev_d;
    logic               lose_prev_q, lose_prev_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [SEL_W-1:0]   digit_sel_q, digit_sel_d;
    logic               win_ev, lose_ev;

    // Prev flops reset high so a level already asserted at reset release is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            win_cnt_q   <= '0;
            lose_cnt_q  <= '0;
            win_prev_q  <= 1'b1;
            lose_prev_q <= 1'b1;
            pre_cnt_q   <= '0;
            digit_sel_q <= '0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            lose_cnt_q  <= lose_cnt_d;
            win_prev_q  <= win_prev_d;
            lose_prev_q <= lose_prev_d;
            pre_cnt_q   <= pre_cnt_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Match FSM: edge-detected events bump counts; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        lose_cnt_d  = lose_cnt_q;
        win_prev_d  = win_in;
        lose_prev_d = lose_in;
        win_ev      = win_in & ~win_prev_q;
        lose_ev     = lose_in & ~lose_prev_q;

        if (clear) begin
            state_d    = ST_PLAY;
            win_cnt_d  = '0;
            lose_cnt_d = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (win_ev && !lose_ev) begin
                        win_cnt_d = win_cnt_q + CNT_W'(1);
                        if (win_cnt_d == CNT_W'(MAX_SCORE)) state_d = ST_WON;
                    end else if (lose_ev && !win_ev) begin
                        lose_cnt_d = lose_cnt_q + CNT_W'(1);
                        if (lose_cnt_d == CNT_W'(MAX_SCORE)) state_d = ST_LOST;
                    end
                end
                ST_WON, ST_LOST: ;
                default: state_d = ST_PLAY;
            endcase
        end
    end

    // Refresh prescaler and digit index, free-running regardless of match state.
    always_comb begin
        pre_cnt_d   = pre_cnt_q + PRE_W'(1);
        digit_sel_d = digit_sel_q;
        if (pre_cnt_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_cnt_d   = '0;
            digit_sel_d = digit_sel_q + SEL_W'(1);
        end
    end

    assign win       = (state_q == ST_WON)  ? 4'hA : win_cnt_q;
    assign lose      = (state_q == ST_LOST) ? 4'hF : lose_cnt_q;
    assign game_over = (state_q != ST_PLAY);
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_scoreboard_scan_ctrl.sv
// Self-checking bench for scoreboard_scan_ctrl: scoreboard of expected
// win/lose/game_over values plus refresh scan checks at two divider settings.
module tb_scoreboard_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       win_in;
    logic       lose_in;
    logic       clear;
    logic [3:0] win, lose, win1, lose1;
    logic [1:0] digit_sel, digit_sel1;
    logic       game_over, game_over1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] w;
        logic [3:0] l;
        logic       go;
    } exp_t;

    exp_t sb_q[$];

    scoreboard_scan_ctrl #(.REFRESH_DIV(4), .MAX_SCORE(3)) dut (
        .clk(clk), .reset(reset), .win_in(win_in), .lose_in(lose_in), .clear(clear),
        .win(win), .lose(lose), .digit_sel(digit_sel), .game_over(game_over)
    );

    scoreboard_scan_ctrl #(.REFRESH_DIV(1), .MAX_SCORE(3)) dut_div1 (
        .clk(clk), .reset(reset), .win_in(win_in), .lose_in(lose_in), .clear(clear),
        .win(win1), .lose(lose1), .digit_sel(digit_sel1), .game_over(game_over1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] w, input logic [3:0] l, input logic go);
        exp_t e;
        e.w  = w;
        e.l  = l;
        e.go = go;
        sb_q.push_back(e);
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_win"}, 32'(win), 32'(e.w));
            check({tag, "_lose"}, 32'(lose), 32'(e.l));
            check({tag, "_go"}, 32'(game_over), 32'(e.go));
        end
    endtask

    // One-cycle pulse on the inputs; expected values after the rising edge and while low.
    task automatic pulse(input string tag, input logic w_lvl, input logic l_lvl,
                         input logic [3:0] ew, input logic [3:0] el, input logic ego);
        @(negedge clk);
        win_in  = w_lvl;
        lose_in = l_lvl;
        push_exp(ew, el, ego);
        tick();
        compare_out({tag, "_hi"});
        @(negedge clk);
        win_in  = 1'b0;
        lose_in = 1'b0;
        push_exp(ew, el, ego);
        tick();
        compare_out({tag, "_lo"});
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        push_exp(4'd0, 4'd0, 1'b0);
        tick();
        compare_out(tag);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int waited;
        reset   = 1'b1;
        win_in  = 1'b0;
        lose_in = 1'b0;
        clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp(4'd0, 4'd0, 1'b0);
        compare_out("reset");
        check("reset_dsel", 32'(digit_sel), 32'd0);

        // Scan: release reset on a falling edge and count rising edges.
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            check($sformatf("scan4_c%0d", c), 32'(digit_sel), 32'((c / 4) % 4));
            check($sformatf("scan1_c%0d", c), 32'(digit_sel1), 32'(c % 4));
        end

        // Count to a win; further events ignored.
        pulse("win1", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
        pulse("win2", 1'b1, 1'b0, 4'd2, 4'd0, 1'b0);
        pulse("win3", 1'b1, 1'b0, 4'hA, 4'd0, 1'b1);
        pulse("win4", 1'b1, 1'b0, 4'hA, 4'd0, 1'b1);
        pulse("won_lose", 1'b0, 1'b1, 4'hA, 4'd0, 1'b1);
        do_clear("clr1");

        // Held lose level counts once.
        @(negedge clk);
        lose_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            push_exp(4'd0, 4'd1, 1'b0);
            tick();
            compare_out($sformatf("hold_c%0d", c));
            @(negedge clk);
        end
        lose_in = 1'b0;
        push_exp(4'd0, 4'd1, 1'b0);
        tick();
        compare_out("hold_release");
        pulse("lose2", 1'b0, 1'b1, 4'd0, 4'd2, 1'b0);
        pulse("lose3", 1'b0, 1'b1, 4'd0, 4'hF, 1'b1);
        pulse("lost_win", 1'b1, 1'b0, 4'd0, 4'hF, 1'b1);
        do_clear("clr2");

        // Tie and clear priority.
        pulse("tw1", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
        pulse("tie", 1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
        pulse("tw2", 1'b1, 1'b0, 4'd2, 4'd0, 1'b0);
        @(negedge clk);
        win_in = 1'b1;
        clear  = 1'b1;
        push_exp(4'd0, 4'd0, 1'b0);
        tick();
        compare_out("clr_prio");
        @(negedge clk);
        win_in = 1'b0;
        clear  = 1'b0;
        push_exp(4'd0, 4'd0, 1'b0);
        tick();
        compare_out("clr_prio_after");
        pulse("post_clr", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
        pulse("mid2", 1'b1, 1'b0, 4'd2, 4'd0, 1'b0);

        // Wait (bounded) for digit_sel == 2, then reset asynchronously between edges.
        waited = 0;
        while (digit_sel != 2'd2 && waited < 20) begin
            tick();
            waited++;
        end
        check("mid_dsel_reached", 32'(digit_sel), 32'd2);
        check("mid_win", 32'(win), 32'd2);
        #2;
        reset  = 1'b1;
        win_in = 1'b1;
        #1;
        push_exp(4'd0, 4'd0, 1'b0);
        compare_out("async_rst");
        check("async_rst_dsel", 32'(digit_sel), 32'd0);

        // win_in held high across reset release must not count.
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            push_exp(4'd0, 4'd0, 1'b0);
            tick();
            compare_out($sformatf("rel_hold_c%0d", c));
        end
        @(negedge clk);
        win_in = 1'b0;
        push_exp(4'd0, 4'd0, 1'b0);
        tick();
        compare_out("rel_fall");
        pulse("rel_rise", 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
